// File: rtl/lsmitll_merget_sync.sv
// Merges two toggle-encoded pulse streams into one toggle-encoded output,
// enforcing per-input critical timing and buffering bursts in a pending counter.
module lsmitll_merget_sync #(
    parameter int DELAY     = 2,
    parameter int CT_CYCLES = 3,
    parameter int QDEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           a,
    input  logic                           b,
    output logic                           q,
    output logic                           err_ct,
    output logic                           err_ovf,
    output logic [$clog2(QDEPTH+1)-1:0]    pending
);

    localparam int              PW = $clog2(QDEPTH + 1);
    localparam logic [3:0]      CT = 4'(CT_CYCLES);
    localparam logic [PW-1:0]   QD = PW'(QDEPTH);

    // Index 0 is input a, index 1 is input b; a wins the last free slot.
    logic [1:0]    in_now, prev_in, det, ok, req, acc, hist;
    logic [3:0]    age [2];
    logic          emit, ovf, t;
    logic [PW-1:0] base, room, room_b, pending_nxt;

    assign in_now = {b, a};
    assign det    = in_now ^ prev_in;

    // age counts edges since the last accepted pulse, saturating at CT.
    assign ok[0]  = !hist[0] || (age[0] >= CT);
    assign ok[1]  = !hist[1] || (age[1] >= CT);
    assign req    = det & ok;

    assign emit        = (pending != '0);
    assign base        = pending - PW'(emit);
    assign room        = QD - base;
    assign acc[0]      = req[0] && (room != '0);
    assign room_b      = room - PW'(acc[0]);
    assign acc[1]      = req[1] && (room_b != '0);
    assign ovf         = |(req & ~acc);
    assign pending_nxt = base + PW'(acc[0]) + PW'(acc[1]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_in <= '0;
            pending <= '0;
            t       <= 1'b0;
            err_ct  <= 1'b0;
            err_ovf <= 1'b0;
            hist    <= '0;
            for (int i = 0; i < 2; i++) age[i] <= '0;
        end else begin
            prev_in <= in_now;
            pending <= pending_nxt;
            if (emit) t <= ~t;
            err_ct  <= err_ct | (|(det & ~ok));
            err_ovf <= err_ovf | ovf;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    hist[i] <= 1'b1;
                    age[i]  <= 4'd1;
                end else if (hist[i] && (age[i] < CT)) begin
                    age[i]  <= age[i] + 4'd1;
                end
            end
        end
    end

    // The emit toggle already costs one cycle, so DELAY-1 extra stages remain.
    generate
        if (DELAY == 1) begin : g_no_dly
            assign q = t;
        end else begin : g_dly
            logic [DELAY-2:0] dly;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dly <= '0;
                end else begin
                    dly[0] <= t;
                    for (int i = 1; i < DELAY - 1; i++) dly[i] <= dly[i-1];
                end
            end
            assign q = dly[DELAY-2];
        end
    endgenerate

endmodule

// File: doc/lsmitll_merget_sync.md
LSMITLL_MERGET_SYNC -- requirements
Module: lsmitll_merget_sync

Interface
REQ-001 The block SHALL have parameter DELAY, default 2: cycles from an accepted input pulse to the output toggle when no backlog exists; legal range 1..8.
REQ-002 The block SHALL have parameter CT_CYCLES, default 3: minimum cycle spacing between accepted pulses on the same input; legal range 1..15.
REQ-003 The block SHALL have parameter QDEPTH, default 4: capacity of the pending-pulse counter; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 a  input  1  toggle-encoded pulse input; each level change is one pulse; synchronous to clk.
REQ-007 b  input  1  toggle-encoded pulse input; same encoding as a.
REQ-008 q  output  1  merged toggle-encoded output; each level change is one pulse.
REQ-009 err_ct  output  1  sticky flag: a same-input critical-timing violation occurred.
REQ-010 err_ovf  output  1  sticky flag: a pulse was dropped because the pending counter was full.
REQ-011 pending  output  clog2(QDEPTH+1)  number of accepted pulses not yet emitted.

Function
REQ-012 Pulse detection SHALL compare a and b, sampled at each rising edge, against their previous samples; any difference is one detected pulse on that input.
REQ-013 An input with no accepted pulse in its history, or whose last accepted pulse was CT_CYCLES or more edges earlier, SHALL accept a detected pulse.
REQ-014 A pulse detected fewer than CT_CYCLES edges after the last accepted pulse on the same input SHALL be dropped and SHALL set err_ct; the dropped pulse SHALL NOT restart that input's spacing timer.
REQ-015 Pulses on a and b SHALL impose no spacing constraint on each other.
REQ-016 At each edge, emit SHALL be 1 when pending > 0, and pending SHALL update to pending - emit + accepted.
REQ-017 accepted SHALL be limited to QDEPTH - (pending - emit); excess pulses SHALL be dropped, with a dropped before b, and SHALL set err_ovf.
REQ-018 Each emit SHALL toggle an internal register t; q SHALL equal t delayed through DELAY-1 register stages (q equals t when DELAY=1).
REQ-019 An input edge sampled at edge N into an empty counter SHALL produce a q toggle at edge N+DELAY.
REQ-020 When a and b pulses are accepted at the same edge N, q SHALL toggle at edges N+DELAY and N+DELAY+1.
REQ-021 Pulses SHALL be emitted one per cycle in acceptance order; no accepted pulse SHALL be lost or duplicated.
REQ-022 err_ct and err_ovf SHALL remain set until reset; setting either flag SHALL NOT stop normal processing.

Reset
REQ-023 While rst_n=0, the following SHALL be held at 0: q, t, all delay stages, previous input samples, pending, err_ct and err_ovf.
REQ-024 While rst_n=0, both spacing timers SHALL be held in the "no history" state.
REQ-025 Assertion of rst_n mid-operation SHALL discard all pending and in-flight pulses immediately, without waiting for clk.
REQ-026 After rst_n deasserts, a level of 1 on a or b sampled at the first edge SHALL count as one pulse.

Verification (defaults unless stated)
REQ-027 Single pulse: a toggles before edge 10 -> pending=1 after edge 10 and 0 after edge 11; q toggles at edge 12; no flags set.
REQ-028 Simultaneous pulses: a and b toggle before edge 20 -> pending=2 after edge 20; q toggles at edges 22 and 23; no flags set.
REQ-029 Critical timing, violation: a pulses at edges 30 and 32 -> err_ct=1 after edge 32; q toggles once only, at edge 32.
REQ-030 Critical timing, legal spacing: a pulses at edges 40 and 43 -> two q toggles at edges 42 and 45; err_ct stays 0.
REQ-031 Overflow (CT_CYCLES=1): a and b both toggle at every edge from edge 1 -> pending reads 2, 3, 4 after edges 1-3; at edge 4 one b pulse is dropped, err_ovf=1, and pending stays 4.
REQ-032 Reset mid-operation: rst_n low while pending=3 -> q=0, pending=0 and both flags 0 with no clk edge; after release, scenario REQ-027 repeats exactly.
